demux32_8: RTL and testbench



---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux32_8_if.sv | 30 +++
 rtl/demux32_8.sv | 111 +++++++++++
 tb/tb_demux32_8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, state encoding and byte-slice helper for the
// 32-to-8 word unpacker.
package demux_pkg;

    localparam int BYTE_W   = 8;
    localparam int N_BYTES  = 4;
    localparam int WORD_W   = BYTE_W * N_BYTES;
    localparam int CNT_W    = $clog2(N_BYTES);
    localparam int LAST_IDX = N_BYTES - 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Byte idx of a word, counted MSB-first (idx 0 is the top byte).
    function automatic logic [BYTE_W-1:0] get_byte(
        input logic [WORD_W-1:0] word,
        input logic [CNT_W-1:0]  idx
    );
        logic [WORD_W-1:0] shifted;
        shifted  = word << (int'(idx) * BYTE_W);
        get_byte = shifted[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/demux32_8_if.sv
// Word-in / byte-out bundle of the unpacker; the slave side is the unpacker.
interface demux32_8_if;
    import demux_pkg::*;

    logic [WORD_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              last_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output valid_out,
        output last_out
    );

endinterface

// File: rtl/demux32_8.sv
// Serialises 32-bit words into four MSB-first bytes, one per clk_4f cycle;
// a one-word pending register keeps back-to-back words gap-free.
module demux32_8
    import demux_pkg::*;
(
    input  logic        clk_4f,
    input  logic        reset_L,
    demux32_8_if.slave  bus
);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [WORD_W-1:0] cur_r, cur_s;
    logic [WORD_W-1:0] pend_r, pend_s;
    logic              pend_v_r, pend_v_s;
    logic [BYTE_W-1:0] data_out_r, data_s;
    logic              valid_out_r, valid_s;
    logic              last_out_r, last_s;
    logic              busy_s;
    logic              emit_s;
    logic              ready_s;
    logic              accept_s;

    // Upstream may only send while the pending slot is free and out of reset.
    assign ready_s  = reset_L & ~pend_v_r;
    assign accept_s = bus.valid_in & ready_s;

    assign bus.ready_out = ready_s;
    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;
    assign bus.last_out  = last_out_r;

    // State register and registered outputs.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cur_r       <= {WORD_W{1'b0}};
            pend_r      <= {WORD_W{1'b0}};
            pend_v_r    <= 1'b0;
            data_out_r  <= {BYTE_W{1'b0}};
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_r       <= cur_s;
            pend_r      <= pend_s;
            pend_v_r    <= pend_v_s;
            data_out_r  <= data_s;
            valid_out_r <= valid_s;
            last_out_r  <= last_s;
        end
    end

    // Next-state: finish the current word first, then the pending word, then bypass.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cur_s    = cur_r;
        pend_s   = pend_r;
        pend_v_s = pend_v_r;
        emit_s   = 1'b0;

        case (state_r)
            ST_SEND: busy_s = (cnt_r != LAST_CNT);
            ST_IDLE: busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase

        if (busy_s) begin
            cnt_s  = cnt_r + CNT_W'(1);
            emit_s = 1'b1;
            if (accept_s) begin
                pend_s   = bus.data_in;
                pend_v_s = 1'b1;
            end else begin
                pend_s   = pend_r;
                pend_v_s = pend_v_r;
            end
        end else if (pend_v_r) begin
            cur_s    = pend_r;
            cnt_s    = {CNT_W{1'b0}};
            pend_v_s = 1'b0;
            state_s  = ST_SEND;
            emit_s   = 1'b1;
        end else if (accept_s) begin
            cur_s   = bus.data_in;
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_SEND;
            emit_s  = 1'b1;
        end else begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_IDLE;
        end
    end

    // Output decode: the byte to register is always byte cnt_s of cur_s.
    always_comb begin
        if (emit_s) begin
            data_s  = get_byte(cur_s, cnt_s);
            valid_s = 1'b1;
            last_s  = (cnt_s == LAST_CNT);
        end else begin
            data_s  = data_out_r;
            valid_s = 1'b0;
            last_s  = 1'b0;
        end
    end

endmodule

// File: tb/tb_demux32_8.sv
// Self-checking bench for demux32_8: directed vector table, hand sequences
// and random traffic against a byte-queue reference model.
module tb_demux32_8;
    import demux_pkg::*;

    logic clk_4f = 1'b0;
    logic reset_L;

    demux32_8_if bus ();

    demux32_8 dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } ebyte_t;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] d;
        logic        exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
    } vec_t;

    // Reference model: bytes still owed to the link, in emission order.
    ebyte_t     mq[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after it.
    task automatic step(input logic rst, input logic v, input logic [31:0] d,
                        output logic acc, output logic rdy);
        logic   exp_ready;
        ebyte_t e;
        reset_L      = rst;
        bus.valid_in = v;
        bus.data_in  = d;
        #1;
        exp_ready = rst && (mq.size() < N_BYTES);
        rdy = bus.ready_out;
        check("ready_out", 32'(bus.ready_out), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk_4f);
        if (!rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = 8'h00;
        end else begin
            if (acc) begin
                for (int i = 0; i < N_BYTES; i++)
                    mq.push_back('{d[31-8*i -: 8], (i == N_BYTES-1)});
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_valid = 1'b1;
                m_data  = e.b;
                m_last  = e.last;
            end else begin
                m_valid = 1'b0;
                m_last  = 1'b0;
            end
        end
        #1;
        check("valid_out", 32'(bus.valid_out), 32'(m_valid));
        check("data_out",  32'(bus.data_out),  32'(m_data));
        check("last_out",  32'(bus.last_out),  32'(m_last));
        @(negedge clk_4f);
    endtask

    vec_t        tbl[19];
    logic        acc, rdy;
    logic        hold, v_r, rst_r;
    logic [31:0] d_r;
    logic [7:0]  beef[4];

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 32'h0;
        reset_L      = 1'b0;
        m_data       = 8'h00;
        m_valid      = 1'b0;
        m_last       = 1'b0;

        //          rst   v     data          rdy   vld   byte   last
        tbl[0]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'hA1B2C3D4, 1'b1, 1'b1, 8'hA1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'hB2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'hC3, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'hD4, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'hD4, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h01020304, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h05060708, 1'b1, 1'b1, 8'h02, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h090A0B0C, 1'b0, 1'b1, 8'h03, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h090A0B0C, 1'b0, 1'b1, 8'h04, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'h090A0B0C, 1'b0, 1'b1, 8'h05, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'h090A0B0C, 1'b1, 1'b1, 8'h06, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 8'h07, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 8'h08, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 8'h09, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0A, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0B, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0C, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'h0C, 1'b0};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].d, acc, rdy);
            check("tbl_ready", 32'(rdy),           32'(tbl[i].exp_ready));
            check("tbl_valid", 32'(bus.valid_out), 32'(tbl[i].exp_valid));
            check("tbl_data",  32'(bus.data_out),  32'(tbl[i].exp_data));
            check("tbl_last",  32'(bus.last_out),  32'(tbl[i].exp_last));
        end

        // Reset after byte1 with a word parked in pend: nothing of either survives.
        step(1'b1, 1'b1, 32'h11223344, acc, rdy);
        step(1'b1, 1'b1, 32'h55667788, acc, rdy);
        check("rst_mid_byte1", 32'(bus.data_out), 32'h22);
        step(1'b0, 1'b0, 32'h0, acc, rdy);
        check("rst_mid_valid", 32'(bus.valid_out), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0, acc, rdy);
            check("rst_mid_quiet", 32'(bus.valid_out), 32'h0);
        end

        // valid_in dropped right after the accept still yields all four bytes.
        beef[0] = 8'hDE; beef[1] = 8'hAD; beef[2] = 8'hBE; beef[3] = 8'hEF;
        step(1'b1, 1'b1, 32'hDEADBEEF, acc, rdy);
        check("beef_b0", 32'(bus.data_out), 32'(beef[0]));
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b0, $urandom, acc, rdy);
            check("beef_byte",  32'(bus.data_out),  32'(beef[i]));
            check("beef_valid", 32'(bus.valid_out), 32'h1);
        end
        check("beef_last", 32'(bus.last_out), 32'h1);

        // Idle with toggling data_in: output frozen on the last byte.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, $urandom, acc, rdy);
            check("idle_valid", 32'(bus.valid_out), 32'h0);
            check("idle_data",  32'(bus.data_out),  32'hEF);
        end

        // Random traffic; a stalled word is held until it is taken.
        hold = 1'b0;
        v_r  = 1'b0;
        d_r  = 32'h0;
        for (int i = 0; i < 800; i++) begin
            if (!hold) begin
                v_r = ($urandom_range(0, 3) != 0);
                d_r = $urandom;
            end
            rst_r = ($urandom_range(0, 63) != 0);
            step(rst_r, v_r, d_r, acc, rdy);
            hold = rst_r && v_r && !acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
